// File: rtl/qarctan_pkg.sv
// ============================================================================
// Module      : qarctan_pkg
// Description : Shared types, quadrant constants and the round-toward-zero
//               shift for the sequential quantized arctan stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qarctan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_SCALE  = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  typedef logic signed [63:0] wide_t;

  typedef struct packed {
    wide_t quad1;
    wide_t quad3;
    wide_t pi_q;
  } quad_t;

  // pi * 2^32, truncated; valid for frac <= 32.
  localparam logic [63:0] c_PI_FX32 = 64'd13493037704;

  function automatic quad_t quad_consts(input int unsigned frac);
    quad_t c;
    c.pi_q  = wide_t'(c_PI_FX32 >> (32 - frac));
    c.quad1 = wide_t'(c_PI_FX32 >> (34 - frac));
    c.quad3 = wide_t'((c_PI_FX32 * 64'd3) >> (34 - frac));
    return c;
  endfunction

  function automatic wide_t trunc0_shr(input wide_t x, input int unsigned sh);
    wide_t mag;
    mag = x[63] ? -x : x;
    mag = mag >> sh;
    return x[63] ? -mag : mag;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qarctan_seq_if.sv
// ============================================================================
// Module      : qarctan_seq_if
// Description : FIFO-side bundle of the arctan stage (I/R pop, angle push).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface qarctan_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] I_dout;
  logic                  I_empty;
  logic                  I_rd_en;
  logic [DATA_WIDTH-1:0] R_dout;
  logic                  R_empty;
  logic                  R_rd_en;
  logic [DATA_WIDTH-1:0] out_din;
  logic                  out_full;
  logic                  out_wr_en;

  // master: the arctan block, which owns every FIFO strobe.
  modport master (
    input  I_dout, I_empty, R_dout, R_empty, out_full,
    output I_rd_en, R_rd_en, out_din, out_wr_en
  );

  modport slave (
    output I_dout, I_empty, R_dout, R_empty, out_full,
    input  I_rd_en, R_rd_en, out_din, out_wr_en
  );
endinterface

`default_nettype wire

// File: rtl/seq_udiv.sv
// ============================================================================
// Module      : seq_udiv
// Description : Unsigned restoring divider, one quotient bit per cycle, MSB
//               first. Requires num_i < (den_i << Q_BITS) and Q_BITS >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_udiv #(
  parameter int NUM_W  = 43,
  parameter int DEN_W  = 34,
  parameter int Q_BITS = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic [NUM_W-1:0]  num_i,
  input  logic [DEN_W-1:0]  den_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [Q_BITS-1:0] quot_o
);
  localparam int c_CNT_W = $clog2(Q_BITS + 1);

  logic [DEN_W-1:0]   rem_q,  rem_d;
  logic [Q_BITS-1:0]  sr_q,   sr_d;
  logic [Q_BITS-1:0]  quot_q, quot_d;
  logic [DEN_W-1:0]   den_q,  den_d;
  logic [c_CNT_W-1:0] cnt_q,  cnt_d;
  logic               busy_q, busy_d;

  logic [DEN_W:0]     shifted;
  logic [DEN_W:0]     diff;
  logic               fits;

  always_comb begin
    shifted = {rem_q, sr_q[Q_BITS-1]};
    diff    = shifted - {1'b0, den_q};
    // rem stays below den, so a borrow shows up as the top bit of diff.
    fits    = ~diff[DEN_W];

    rem_d  = rem_q;
    sr_d   = sr_q;
    quot_d = quot_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    if (start_i) begin
      // The bits above the quotient range are already smaller than den.
      rem_d  = DEN_W'(num_i[NUM_W-1:Q_BITS]);
      sr_d   = num_i[Q_BITS-1:0];
      quot_d = '0;
      den_d  = den_i;
      cnt_d  = c_CNT_W'(Q_BITS);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = fits ? diff[DEN_W-1:0] : shifted[DEN_W-1:0];
      sr_d   = {sr_q[Q_BITS-2:0], 1'b0};
      quot_d = {quot_q[Q_BITS-2:0], fits};
      cnt_d  = cnt_q - c_CNT_W'(1);
      busy_d = (cnt_q != c_CNT_W'(1));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      sr_q   <= '0;
      quot_q <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      sr_q   <= sr_d;
      quot_q <= quot_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == c_CNT_W'(1));
  assign quot_o = quot_q;

endmodule

`default_nettype wire

// File: rtl/qarctan_seq.sv
// ============================================================================
// Module      : qarctan_seq
// Description : Multi-cycle quantized atan2(I,R) between the demod products
//               and the deemphasis filters. Define QARCTAN_DEMOD_EN to output
//               the wrapped phase difference instead of the raw angle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qarctan_seq
  import qarctan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10
) (
  input  logic          clock,
  input  logic          reset,
  qarctan_seq_if.master fifo
);
  localparam int    c_W      = DATA_WIDTH + 2;
  localparam int    c_MAG_W  = c_W - 1;
  localparam int    c_Q_BITS = FRAC_BITS + 1;
  localparam int    c_NUM_W  = c_MAG_W + FRAC_BITS;
  localparam quad_t c_QUAD   = quad_consts(FRAC_BITS);

  state_t state_q, state_d;
  logic   neg_num_q, neg_num_d;
  logic   quad3_q, quad3_d;
  logic   neg_i_q, neg_i_d;
  logic [DATA_WIDTH-1:0] angle_q, angle_d;
  logic [DATA_WIDTH-1:0] result;

  logic [c_W-1:0]      i_ext, r_ext, abs_i, num, den;
  logic [c_MAG_W-1:0]  num_mag;
  logic [c_NUM_W-1:0]  dividend;
  logic [c_Q_BITS-1:0] quot;
  logic                div_busy, div_done;
  logic                pop, push;

  function automatic logic [DATA_WIDTH-1:0] scale_angle(
    input logic [c_Q_BITS-1:0] q,
    input logic                neg_num,
    input logic                quad3,
    input logic                neg_i
  );
    wide_t r, t, base, ang, q1;
    q1   = c_QUAD.quad1;
    r    = neg_num ? -wide_t'(q) : wide_t'(q);
    t    = trunc0_shr(q1 * r, FRAC_BITS);
    base = quad3 ? c_QUAD.quad3 : q1;
    ang  = base - t;
    return DATA_WIDTH'(neg_i ? -ang : ang);
  endfunction

  always_comb begin
    i_ext    = {{2{fifo.I_dout[DATA_WIDTH-1]}}, fifo.I_dout};
    r_ext    = {{2{fifo.R_dout[DATA_WIDTH-1]}}, fifo.R_dout};
    // The +1 keeps the denominator non-zero even for I=R=0.
    abs_i    = (i_ext[c_W-1] ? -i_ext : i_ext) + c_W'(1);
    if (!r_ext[c_W-1]) begin
      num = r_ext - abs_i;
      den = r_ext + abs_i;
    end else begin
      num = r_ext + abs_i;
      den = abs_i - r_ext;
    end
    num_mag  = num[c_W-1] ? c_MAG_W'(-num) : num[c_MAG_W-1:0];
    dividend = {num_mag, {FRAC_BITS{1'b0}}};
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    push      = 1'b0;
    neg_num_d = neg_num_q;
    quad3_d   = quad3_q;
    neg_i_d   = neg_i_q;
    angle_d   = angle_q;
    case (state_q)
      ST_IDLE: begin
        // Gated on reset so a non-empty FIFO is never popped while in reset.
        if (reset && !fifo.I_empty && !fifo.R_empty && !div_busy) begin
          pop       = 1'b1;
          neg_num_d = num[c_W-1];
          quad3_d   = r_ext[c_W-1];
          neg_i_d   = i_ext[c_W-1];
          state_d   = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_done) state_d = ST_SCALE;
      end
      ST_SCALE: begin
        angle_d = scale_angle(quot, neg_num_q, quad3_q, neg_i_q);
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (!fifo.out_full) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      neg_num_q <= 1'b0;
      quad3_q   <= 1'b0;
      neg_i_q   <= 1'b0;
      angle_q   <= '0;
    end else begin
      state_q   <= state_d;
      neg_num_q <= neg_num_d;
      quad3_q   <= quad3_d;
      neg_i_q   <= neg_i_d;
      angle_q   <= angle_d;
    end
  end

`ifdef QARCTAN_DEMOD_EN
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] diff_q, diff_d;

  function automatic logic [DATA_WIDTH-1:0] wrap_diff(
    input logic signed [DATA_WIDTH-1:0] cur,
    input logic signed [DATA_WIDTH-1:0] prev
  );
    wide_t d, pi;
    pi = c_QUAD.pi_q;
    d  = wide_t'(cur) - wide_t'(prev);
    if (d > pi)       d = d - (pi <<< 1);
    else if (d <= -pi) d = d + (pi <<< 1);
    return DATA_WIDTH'(d);
  endfunction

  always_comb begin
    prev_d = prev_q;
    diff_d = diff_q;
    if (state_q == ST_SCALE) diff_d = wrap_diff(angle_d, prev_q);
    if (push)                prev_d = angle_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      diff_q <= '0;
    end else begin
      prev_q <= prev_d;
      diff_q <= diff_d;
    end
  end

  assign result = diff_q;
`else
  assign result = angle_q;
`endif

  seq_udiv #(
    .NUM_W  (c_NUM_W),
    .DEN_W  (c_W),
    .Q_BITS (c_Q_BITS)
  ) u_div (
    .clock   (clock),
    .reset   (reset),
    .start_i (pop),
    .num_i   (dividend),
    .den_i   (den),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quot_o  (quot)
  );

  assign fifo.I_rd_en   = pop;
  assign fifo.R_rd_en   = pop;
  assign fifo.out_wr_en = push;
  assign fifo.out_din   = (state_q == ST_OUT) ? result : '0;

endmodule

`default_nettype wire

// File: tb/tb_qarctan_seq.sv
// ============================================================================
// Module      : tb_qarctan_seq
// Description : Directed-vector bench for qarctan_seq (DATA_WIDTH=32, FRAC=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_qarctan_seq;
  localparam int DW = 32;
  localparam int FB = 10;

  typedef struct {
    int r;
    int i;
    int ang;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   wr_count = 0;
  int   rd_count = 0;

  always #5 clock = ~clock;

  qarctan_seq_if #(.DATA_WIDTH(DW)) fifo ();

  qarctan_seq #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clock (clock),
    .reset (reset),
    .fifo  (fifo)
  );

`ifdef QARCTAN_DEMOD_EN
  int model_prev = 0;
`endif

  function automatic int expected(input int ang);
`ifdef QARCTAN_DEMOD_EN
    int d;
    d = ang - model_prev;
    if (d > 3216)       d = d - 6432;
    else if (d <= -3216) d = d + 6432;
    model_prev = ang;
    return d;
`else
    return ang;
`endif
  endfunction

  always @(negedge clock) begin
    if (reset && fifo.out_wr_en) wr_count++;
    if (reset && (fifo.I_rd_en || fifo.R_rd_en)) begin
      rd_count++;
      checks++;
      if (fifo.I_rd_en !== fifo.R_rd_en) begin
        errors++;
        $display("FAIL paired_pop: I_rd_en=%b R_rd_en=%b, required equal", fifo.I_rd_en, fifo.R_rd_en);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic push_pair(input int r, input int i, output bit ok);
    ok = 1'b0;
    @(posedge clock); #1;
    fifo.R_dout  = r;
    fifo.I_dout  = i;
    fifo.I_empty = 1'b0;
    fifo.R_empty = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clock);
      if (fifo.I_rd_en && fifo.R_rd_en) ok = 1'b1;
    end
    @(posedge clock); #1;
    fifo.I_empty = 1'b1;
    fifo.R_empty = 1'b1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout: rd_en=0 for 40 cycles, required 1");
    end
  endtask

  task automatic wait_out(output logic [31:0] v, output int lat, output bit ok);
    ok  = 1'b0;
    v   = '0;
    lat = 0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clock);
      lat++;
      if (fifo.out_wr_en) begin
        ok = 1'b1;
        v  = fifo.out_din;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: wr_en=0 for 80 cycles, required 1");
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock); #2;
    reset = 1'b0;
`ifdef QARCTAN_DEMOD_EN
    model_prev = 0;
`endif
    @(negedge clock); #2;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[16];
    logic [31:0] v;
    int          lat;
    int          wr0, rd0;
    bit          ok, ok2;
    int          int_min;

    int_min  = int'(32'h8000_0000);
    vecs[0]  = '{1000, 0, 3};
    vecs[1]  = '{0, 1000, 1608};
    vecs[2]  = '{0, -1000, -1608};
    vecs[3]  = '{-1000, 0, 3213};
    vecs[4]  = '{1000, 1000, 804};
    vecs[5]  = '{1000, -1000, -804};
    vecs[6]  = '{-1000, 1000, 2412};
    vecs[7]  = '{-1000, -1000, -2412};
    vecs[8]  = '{0, 0, 1608};
    vecs[9]  = '{100, 50, 544};
    vecs[10] = '{-100, -50, -2672};
    vecs[11] = '{2147483647, 0, 1};
    vecs[12] = '{int_min, 0, 3215};
    vecs[13] = '{int_min, int_min, -2412};
    vecs[14] = '{int_min, 2147483647, 2412};
    vecs[15] = '{0, int_min, -1608};

    // Held in reset with both FIFOs non-empty: nothing may move.
    fifo.I_dout   = 32'd5;
    fifo.R_dout   = 32'd5;
    fifo.I_empty  = 1'b0;
    fifo.R_empty  = 1'b0;
    fifo.out_full = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_I_rd_en", 32'(fifo.I_rd_en), 32'd0);
    check("reset_R_rd_en", 32'(fifo.R_rd_en), 32'd0);
    check("reset_wr_en", 32'(fifo.out_wr_en), 32'd0);
    check("reset_out_din", fifo.out_din, 32'd0);
    fifo.I_empty = 1'b1;
    fifo.R_empty = 1'b1;
    @(negedge clock); #2;
    reset = 1'b1;

`ifdef QARCTAN_DEMOD_EN
    push_pair(1000, 0, ok);
    wait_out(v, lat, ok2);
    if (ok && ok2) check("demod_first", v, 32'd3);
    push_pair(0, 1000, ok);
    wait_out(v, lat, ok2);
    if (ok && ok2) check("demod_second", v, 32'd1605);
    pulse_reset();
    push_pair(-1000, 0, ok);
    wait_out(v, lat, ok2);
    if (ok && ok2) check("demod_q3", v, 32'd3213);
    push_pair(0, -1000, ok);
    wait_out(v, lat, ok2);
    if (ok && ok2) check("demod_wrap", v, 32'd1611);
    pulse_reset();
`endif

    for (int n = 0; n < 16; n++) begin
      wr0 = wr_count;
      push_pair(vecs[n].r, vecs[n].i, ok);
      if (ok) begin
        wait_out(v, lat, ok2);
        if (ok2) begin
          check($sformatf("vec%0d_angle", n), v, 32'(expected(vecs[n].ang)));
          if (n == 0) check("latency", 32'(lat), 32'(FB + 3));
        end
        @(negedge clock);
        check($sformatf("vec%0d_writes", n), 32'(wr_count - wr0), 32'd1);
      end
    end

    // Output back-pressure; I present while R stays empty.
    @(posedge clock); #1;
    fifo.out_full = 1'b1;
    wr0 = wr_count;
    rd0 = rd_count;
    push_pair(1000, 0, ok);
    fifo.I_empty = 1'b0;
    repeat (50) @(negedge clock);
    check("full_no_write", 32'(wr_count - wr0), 32'd0);
    check("full_no_pop", 32'(rd_count - rd0), 32'd1);
    @(posedge clock); #1;
    fifo.out_full = 1'b0;
    wait_out(v, lat, ok2);
    if (ok && ok2) check("full_release_value", v, 32'(expected(3)));
    repeat (20) @(negedge clock);
    check("full_single_write", 32'(wr_count - wr0), 32'd1);
    check("half_empty_no_pop", 32'(rd_count - rd0), 32'd1);
    fifo.I_empty = 1'b1;

    // Reset in the middle of DIVIDE drops the sample.
    push_pair(100, 50, ok);
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
`ifdef QARCTAN_DEMOD_EN
    model_prev = 0;
`endif
    #1;
    check("rst_div_rd_en", 32'(fifo.I_rd_en | fifo.R_rd_en), 32'd0);
    check("rst_div_wr_en", 32'(fifo.out_wr_en), 32'd0);
    check("rst_div_out_din", fifo.out_din, 32'd0);
    wr0 = wr_count;
    @(negedge clock); #2;
    reset = 1'b1;
    push_pair(-100, -50, ok);
    wait_out(v, lat, ok2);
    if (ok && ok2) check("after_rst_div_value", v, 32'(expected(-2672)));
    @(negedge clock);
    check("after_rst_div_writes", 32'(wr_count - wr0), 32'd1);

    // Reset while a result is stalled in OUT: it must never be written.
    @(posedge clock); #1;
    fifo.out_full = 1'b1;
    push_pair(1000, 1000, ok);
    repeat (20) @(negedge clock);
    #2 reset = 1'b0;
`ifdef QARCTAN_DEMOD_EN
    model_prev = 0;
`endif
    #1;
    check("rst_out_out_din", fifo.out_din, 32'd0);
    check("rst_out_wr_en", 32'(fifo.out_wr_en), 32'd0);
    wr0 = wr_count;
    @(negedge clock); #2;
    reset = 1'b1;
    fifo.out_full = 1'b0;
    repeat (20) @(negedge clock);
    check("rst_out_dropped", 32'(wr_count - wr0), 32'd0);
    push_pair(-1000, 0, ok);
    wait_out(v, lat, ok2);
    if (ok && ok2) check("after_rst_out_value", v, 32'(expected(3213)));

    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
